// File: rtl/switch_async_pkt_fifo.sv
// Dual-clock packet FIFO. Words are written speculatively in the WriteClock
// domain and become visible to the ReadClock domain only once end-of-packet
// commits them. Packets can be dropped explicitly or auto-dropped on overflow.
module switch_async_pkt_fifo #(
  parameter int pDepthWidth   = 5,
  parameter int pWordWidth    = 16,
  parameter int pSyncStages   = 2,
  parameter int pAFullThresh  = 4,
  parameter int pAEmptyThresh = 2
) (
  input  logic                   inReset,
  input  logic                   WriteClock,
  input  logic                   ReadClock,
  input  logic                   iWEn,
  input  logic [pWordWidth-1:0]  ivDataIn,
  input  logic                   iWEop,
  input  logic                   iWDrop,
  output logic                   qWFull,
  output logic                   qWAlmostFull,
  output logic [pDepthWidth:0]   qvWCount,
  output logic                   qWOverflow,
  input  logic                   iREn,
  output logic [pWordWidth-1:0]  ovDataOut,
  output logic                   ovREop,
  output logic                   qREmpty,
  output logic                   qRAlmostEmpty,
  output logic [pDepthWidth:0]   qvRNumberLeft
);

  // state     | meaning
  // stIdle    | between packets; next accepted word opens a packet
  // stActive  | packet in progress; its words are held uncommitted
  // stDiscard | packet overflowed; swallow words until EOP or drop
  typedef enum logic [1:0] {stIdle, stActive, stDiscard} wState_t;

  localparam int                 cDepth  = 1 << pDepthWidth;
  localparam logic [pDepthWidth:0] cDepthP = (pDepthWidth+1)'(cDepth);
  localparam logic [pDepthWidth:0] cAFull  = (pDepthWidth+1)'(pAFullThresh);
  localparam logic [pDepthWidth:0] cAEmpty = (pDepthWidth+1)'(pAEmptyThresh);
  localparam logic [pDepthWidth:0] cOne    = (pDepthWidth+1)'(1);

  function automatic logic [pDepthWidth:0] bin2gray(input logic [pDepthWidth:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [pDepthWidth:0] gray2bin(input logic [pDepthWidth:0] g);
    logic [pDepthWidth:0] b;
    b[pDepthWidth] = g[pDepthWidth];
    for (int i = pDepthWidth - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  wState_t              wState;
  logic [pWordWidth:0]  mem [cDepth];
  logic [pDepthWidth:0] wptrSpec, wptrCommit, wptrCommitGray;
  logic [pDepthWidth:0] wptrSpecNext, wCountNext, rptrSyncBin;
  logic [pDepthWidth:0] rSyncW [pSyncStages];
  logic [pDepthWidth:0] wSyncR [pSyncStages];
  logic [pDepthWidth:0] rptr, rptrNext, rptrGray, wptrCommitSyncBin, rAvailNext;
  logic                 wAccept, wRewind, rPop;

  // Decode this cycle's write action; a rewind (drop or overflow) beats a write.
  always_comb begin
    wRewind = (wState == stActive) && (iWDrop || (iWEn && qWFull));
    wAccept = iWEn && !qWFull && (wState != stDiscard) && !wRewind;
    wptrSpecNext = wptrSpec;
    if (wRewind)      wptrSpecNext = wptrCommit;
    else if (wAccept) wptrSpecNext = wptrSpec + cOne;
    wCountNext = wptrSpecNext - rptrSyncBin;
  end

  // Storage: EOP rides in the top bit; contents are deliberately not reset.
  always_ff @(posedge WriteClock) begin
    if (wAccept) mem[wptrSpec[pDepthWidth-1:0]] <= {iWEop, ivDataIn};
  end

  // Write FSM, pointers and write-side flags (flags use the post-update pointer).
  always_ff @(posedge WriteClock or negedge inReset) begin
    if (!inReset) begin
      wState         <= stIdle;
      wptrSpec       <= '0;
      wptrCommit     <= '0;
      wptrCommitGray <= '0;
      qWOverflow     <= 1'b0;
      qvWCount       <= '0;
      qWFull         <= 1'b0;
      qWAlmostFull   <= 1'b0;
    end else begin
      wptrSpec   <= wptrSpecNext;
      qWOverflow <= 1'b0;
      if (wAccept && iWEop) begin
        wptrCommit     <= wptrSpec + cOne;
        wptrCommitGray <= bin2gray(wptrSpec + cOne);
      end
      case (wState)
        stIdle: begin
          if (wAccept && !iWEop) wState <= stActive;
        end
        stActive: begin
          if (iWDrop) begin
            wState <= stIdle;
          end else if (iWEn && qWFull) begin
            wState     <= stDiscard;
            qWOverflow <= 1'b1;
          end else if (wAccept && iWEop) begin
            wState <= stIdle;
          end
        end
        stDiscard: begin
          if (iWDrop || (iWEn && iWEop)) wState <= stIdle;
        end
        default: wState <= stIdle;
      endcase
      qvWCount     <= wCountNext;
      qWFull       <= (wCountNext == cDepthP);
      qWAlmostFull <= ((cDepthP - wCountNext) <= cAFull);
    end
  end

  // Bring the read pointer (Gray) into the write domain.
  always_ff @(posedge WriteClock or negedge inReset) begin
    if (!inReset) begin
      for (int i = 0; i < pSyncStages; i++) rSyncW[i] <= '0;
    end else begin
      rSyncW[0] <= rptrGray;
      for (int i = 1; i < pSyncStages; i++) rSyncW[i] <= rSyncW[i-1];
    end
  end

  assign rptrSyncBin = gray2bin(rSyncW[pSyncStages-1]);

  // Bring the committed write pointer (Gray) into the read domain.
  always_ff @(posedge ReadClock or negedge inReset) begin
    if (!inReset) begin
      for (int i = 0; i < pSyncStages; i++) wSyncR[i] <= '0;
    end else begin
      wSyncR[0] <= wptrCommitGray;
      for (int i = 1; i < pSyncStages; i++) wSyncR[i] <= wSyncR[i-1];
    end
  end

  assign wptrCommitSyncBin = gray2bin(wSyncR[pSyncStages-1]);
  assign rPop              = iREn && !qREmpty;
  assign rptrNext          = rptr + (rPop ? cOne : '0);
  assign rAvailNext        = wptrCommitSyncBin - rptrNext;

  // Show-ahead output register: always holds the word at the read pointer when one is committed.
  always_ff @(posedge ReadClock or negedge inReset) begin
    if (!inReset) begin
      rptr          <= '0;
      rptrGray      <= '0;
      qREmpty       <= 1'b1;
      qRAlmostEmpty <= 1'b1;
      qvRNumberLeft <= '0;
      ovDataOut     <= '0;
      ovREop        <= 1'b0;
    end else begin
      rptr          <= rptrNext;
      rptrGray      <= bin2gray(rptrNext);
      qREmpty       <= (rAvailNext == '0);
      qRAlmostEmpty <= (rAvailNext <= cAEmpty);
      qvRNumberLeft <= rAvailNext;
      if (rAvailNext != '0) {ovREop, ovDataOut} <= mem[rptrNext[pDepthWidth-1:0]];
    end
  end

endmodule

// File: tb/tb_switch_async_pkt_fifo.sv
// Bench for switch_async_pkt_fifo: directed write-side vector table, directed
// read-side sequences, then scoreboarded random traffic at three clock ratios.
module tb_switch_async_pkt_fifo;

  logic       inReset, WriteClock, ReadClock;
  logic       iWEn, iWEop, iWDrop, iREn;
  logic [7:0] ivDataIn, ovDataOut;
  logic       qWFull, qWAlmostFull, qWOverflow, ovREop, qREmpty, qRAlmostEmpty;
  logic [4:0] qvWCount, qvRNumberLeft;

  int wHalf = 5;
  int rHalf = 7;
  int total = 0;
  int bad   = 0;
  bit writerDone;
  logic [8:0] expQ[$];

  typedef struct {
    logic       en;
    logic [7:0] data;
    logic       eop;
    logic       drop;
    logic       expFull;
    logic [4:0] expCount;
    logic       expOvf;
    logic       expAF;
  } wVec_t;

  wVec_t vt[$];

  switch_async_pkt_fifo #(
    .pDepthWidth(4), .pWordWidth(8), .pSyncStages(2), .pAFullThresh(4), .pAEmptyThresh(2)
  ) dut (
    .inReset(inReset), .WriteClock(WriteClock), .ReadClock(ReadClock),
    .iWEn(iWEn), .ivDataIn(ivDataIn), .iWEop(iWEop), .iWDrop(iWDrop),
    .qWFull(qWFull), .qWAlmostFull(qWAlmostFull), .qvWCount(qvWCount), .qWOverflow(qWOverflow),
    .iREn(iREn), .ovDataOut(ovDataOut), .ovREop(ovREop), .qREmpty(qREmpty),
    .qRAlmostEmpty(qRAlmostEmpty), .qvRNumberLeft(qvRNumberLeft)
  );

  initial begin
    WriteClock = 0;
    forever #(wHalf) WriteClock = ~WriteClock;
  end

  initial begin
    ReadClock = 0;
    forever #(rHalf) ReadClock = ~ReadClock;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wTick();
    @(posedge WriteClock);
    #1;
  endtask

  task automatic rTick();
    @(posedge ReadClock);
    #1;
  endtask

  task automatic wDrive(logic en, logic [7:0] d, logic eop, logic drop);
    iWEn = en; ivDataIn = d; iWEop = eop; iWDrop = drop;
    wTick();
    iWEn = 0; iWEop = 0; iWDrop = 0;
  endtask

  task automatic rPop(string nm, logic [7:0] d, logic eop);
    chk({nm, "_ne"}, qREmpty, 0);
    chk({nm, "_data"}, ovDataOut, d);
    chk({nm, "_eop"}, ovREop, eop);
    iREn = 1;
    rTick();
    iREn = 0;
  endtask

  task automatic waitNE(string nm, int lim);
    int c;
    c = 0;
    while (qREmpty && c < lim) begin
      rTick();
      c++;
    end
    chk(nm, qREmpty, 0);
  endtask

  task automatic doReset();
    iWEn = 0; iWEop = 0; iWDrop = 0; iREn = 0; ivDataIn = 0;
    inReset = 0;
    repeat (3) @(posedge ReadClock);
    repeat (3) @(posedge WriteClock);
    #3 inReset = 1;
    wTick(); rTick(); wTick();
  endtask

  function automatic void addW(logic en, logic [7:0] d, logic eop, logic drop,
                               logic f, int c, logic o, logic af);
    wVec_t v;
    v.en = en; v.data = d; v.eop = eop; v.drop = drop;
    v.expFull = f; v.expCount = c[4:0]; v.expOvf = o; v.expAF = af;
    vt.push_back(v);
  endfunction

  task automatic applyW(int first, int last);
    for (int i = first; i < last; i++) begin
      iWEn = vt[i].en; ivDataIn = vt[i].data; iWEop = vt[i].eop; iWDrop = vt[i].drop;
      wTick();
      iWEn = 0; iWEop = 0; iWDrop = 0;
      chk($sformatf("vec%0d_full", i), qWFull, vt[i].expFull);
      chk($sformatf("vec%0d_count", i), qvWCount, vt[i].expCount);
      chk($sformatf("vec%0d_ovf", i), qWOverflow, vt[i].expOvf);
      chk($sformatf("vec%0d_afull", i), qWAlmostFull, vt[i].expAF);
    end
  endtask

  task automatic writer(int nPkts);
    int mState, len, dropAt, w, budget;
    logic en, eop, drop, full, expOvf;
    logic [7:0] d;
    logic [8:0] pend[$];
    mState = 0;
    for (int p = 0; p < nPkts; p++) begin
      len    = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(1, 6));
      dropAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, len)) : 0;
      w = 0;
      budget = 0;
      while (w < len && budget < 400) begin
        budget++;
        full = qWFull;
        en   = !((len <= 16 && full) || $urandom_range(0, 4) == 0);
        eop  = en && (w == len - 1);
        drop = en && (w + 1 == dropAt);
        d    = 8'($urandom);
        expOvf = 0;
        case (mState)
          0: if (en && !full) begin
               pend.push_back({eop, d});
               if (eop) begin
                 foreach (pend[k]) expQ.push_back(pend[k]);
                 pend.delete();
               end else mState = 1;
             end
          1: if (drop) begin
               pend.delete(); mState = 0;
             end else if (en && full) begin
               pend.delete(); mState = 2; expOvf = 1;
             end else if (en) begin
               pend.push_back({eop, d});
               if (eop) begin
                 foreach (pend[k]) expQ.push_back(pend[k]);
                 pend.delete();
                 mState = 0;
               end
             end
          default: if (drop || (en && eop)) mState = 0;
        endcase
        wDrive(en, d, eop, drop);
        chk("rnd_ovf", qWOverflow, expOvf);
        if (en) w++;
        if (drop) break;
      end
      if (budget >= 400) begin
        chk("wr_budget", 1, 0);
        break;
      end
    end
    writerDone = 1;
  endtask

  task automatic reader();
    int quiet, cyc;
    logic en;
    logic [8:0] e;
    quiet = 0;
    cyc = 0;
    while (quiet < 30 && cyc < 30000) begin
      cyc++;
      en = ($urandom_range(0, 3) != 0);
      iREn = en;
      if (en && !qREmpty) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_extra: got %0h want nothing", {ovREop, ovDataOut});
        end else begin
          e = expQ.pop_front();
          chk("rd_word", {ovREop, ovDataOut}, e);
        end
      end
      rTick();
      if (writerDone && expQ.size() == 0) quiet++;
      else quiet = 0;
    end
    iREn = 0;
    chk("rd_drained", expQ.size(), 0);
    chk("wr_done", writerDone, 1);
    chk("rd_final_empty", qREmpty, 1);
  endtask

  task automatic runRandom(int wh, int rh, int n);
    wHalf = wh;
    rHalf = rh;
    doReset();
    writerDone = 0;
    expQ.delete();
    fork
      writer(n);
      reader();
    join
  endtask

  initial begin
    int nOvf, cyc;
    bit saw;
    iWEn = 0; iWEop = 0; iWDrop = 0; iREn = 0; ivDataIn = 0; inReset = 0;
    #20;
    chk("rst_in_empty", qREmpty, 1);
    chk("rst_in_wcount", qvWCount, 0);
    doReset();
    chk("rst_full", qWFull, 0);
    chk("rst_afull", qWAlmostFull, 0);
    chk("rst_wcount", qvWCount, 0);
    chk("rst_ovf", qWOverflow, 0);
    chk("rst_empty", qREmpty, 1);
    chk("rst_aempty", qRAlmostEmpty, 1);
    chk("rst_left", qvRNumberLeft, 0);
    chk("rst_data", ovDataOut, 0);
    chk("rst_eop", ovREop, 0);

    // overflow: 16 words fill, 17th overflows, 18th (EOP) closes the discard
    for (int i = 0; i < 16; i++) addW(1, 8'(i), 0, 0, (i == 15), i + 1, 0, (i + 1 >= 12));
    addW(1, 8'h40, 0, 0, 0, 0, 1, 0);
    addW(1, 8'h41, 1, 0, 0, 0, 0, 0);
    nOvf = vt.size();
    // drop (coincident with a write) then a 2-word packet, then a drop in idle
    addW(1, 8'hD0, 0, 0, 0, 1, 0, 0);
    addW(1, 8'hD1, 0, 0, 0, 2, 0, 0);
    addW(1, 8'hD2, 0, 0, 0, 3, 0, 0);
    addW(1, 8'hEE, 0, 1, 0, 0, 0, 0);
    addW(1, 8'hA0, 0, 0, 0, 1, 0, 0);
    addW(1, 8'hA1, 1, 0, 0, 2, 0, 0);
    addW(0, 8'h00, 0, 1, 0, 2, 0, 0);
    addW(0, 8'h00, 0, 0, 0, 2, 0, 0);

    applyW(0, nOvf);
    repeat (10) rTick();
    chk("ovf_empty", qREmpty, 1);
    chk("ovf_left", qvRNumberLeft, 0);
    wTick();
    applyW(nOvf, vt.size());

    waitNE("drop_visible", 10);
    chk("drop_left", qvRNumberLeft, 2);
    rPop("a0", 8'hA0, 0);
    rPop("a1", 8'hA1, 1);
    chk("drop_after_empty", qREmpty, 1);

    // 5-word packet: invisible until EOP, then read back in order
    wTick();
    for (int i = 0; i < 4; i++) wDrive(1, 8'(8'h10 + i), 0, 0);
    saw = 0;
    repeat (10) begin
      rTick();
      if (!qREmpty) saw = 1;
    end
    chk("pre_eop_empty", saw, 0);
    wTick();
    wDrive(1, 8'h14, 1, 0);
    cyc = 0;
    while (qREmpty && cyc < 12) begin
      rTick();
      cyc++;
    end
    chk("commit_latency_le5", (cyc <= 5), 1);
    chk("p5_left", qvRNumberLeft, 5);
    for (int i = 0; i < 5; i++) rPop($sformatf("p5_%0d", i), 8'(8'h10 + i), (i == 4));
    chk("p5_empty", qREmpty, 1);

    // almost-full / almost-empty thresholds
    cyc = 0;
    while (qvWCount != 0 && cyc < 20) begin
      wTick();
      cyc++;
    end
    chk("wcount_drain", qvWCount, 0);
    for (int i = 0; i < 12; i++) begin
      wDrive(1, 8'(8'h30 + i), (i == 11), 0);
      if (i == 10) begin
        chk("af11_count", qvWCount, 11);
        chk("af11_afull", qWAlmostFull, 0);
      end
    end
    chk("af12_count", qvWCount, 12);
    chk("af12_afull", qWAlmostFull, 1);
    chk("af12_full", qWFull, 0);
    waitNE("ae_visible", 10);
    chk("ae12_left", qvRNumberLeft, 12);
    chk("ae12_aempty", qRAlmostEmpty, 0);
    for (int i = 0; i < 9; i++) rPop($sformatf("ae_%0d", i), 8'(8'h30 + i), 0);
    chk("ae3_left", qvRNumberLeft, 3);
    chk("ae3_aempty", qRAlmostEmpty, 0);
    rPop("ae_9", 8'h39, 0);
    chk("ae2_left", qvRNumberLeft, 2);
    chk("ae2_aempty", qRAlmostEmpty, 1);
    rPop("ae_10", 8'h3A, 0);
    rPop("ae_11", 8'h3B, 1);
    chk("ae0_empty", qREmpty, 1);
    chk("ae0_left", qvRNumberLeft, 0);

    // reset in the middle of traffic
    wTick();
    wDrive(1, 8'h55, 1, 0);
    wDrive(1, 8'h56, 0, 0);
    wDrive(1, 8'h57, 0, 0);
    waitNE("mid_visible", 10);
    iREn = 1; iWEn = 1; ivDataIn = 8'h58;
    #2 inReset = 0;
    #4;
    chk("mid_rst_empty", qREmpty, 1);
    chk("mid_rst_wcount", qvWCount, 0);
    chk("mid_rst_left", qvRNumberLeft, 0);
    chk("mid_rst_full", qWFull, 0);
    chk("mid_rst_data", ovDataOut, 0);
    iREn = 0; iWEn = 0;
    repeat (3) @(posedge WriteClock);
    #3 inReset = 1;
    repeat (8) rTick();
    chk("post_rst_empty", qREmpty, 1);
    chk("post_rst_left", qvRNumberLeft, 0);
    wTick();
    chk("post_rst_wcount", qvWCount, 0);
    wDrive(1, 8'h77, 1, 0);
    waitNE("post_rst_visible", 10);
    chk("post_rst_left1", qvRNumberLeft, 1);
    rPop("post_rst_word", 8'h77, 1);

    // random traffic at 1:1, write-fast and read-fast ratios
    runRandom(5, 5, 60);
    runRandom(5, 16, 60);
    runRandom(16, 5, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_async_pkt_fifo.md
Name: switch_async_pkt_fifo

Overview:
- Dual-clock, parametrised packet FIFO for the 10G Ethernet switch datapath; next generation of the switch async FIFO.
- Adds packet-commit semantics: words become visible to the read domain only after end-of-packet is written. A packet can be discarded explicitly or automatically on overflow.
- Adds configurable synchroniser depth, almost-full/almost-empty flags and an EOP sideband bit.
- Sits between the MAC RX framer (WriteClock domain) and the switch core (ReadClock domain).

Parameters:
- pDepthWidth, 5, log2 of FIFO depth in words (depth = 2^pDepthWidth), minimum 3.
- pWordWidth, 16, data word width.
- pSyncStages, 2, flip-flops per Gray pointer synchroniser, 2..4.
- pAFullThresh, 4, qWAlmostFull asserts when free words <= this value.
- pAEmptyThresh, 2, qRAlmostEmpty asserts when readable words <= this value.

Ports:
- inReset  in  1  reset, asynchronous, active-low, applied to both domains.
- WriteClock  in  1  write-domain clock.
- ReadClock  in  1  read-domain clock.
- iWEn  in  1  write request.
- ivDataIn  in  pWordWidth  write data.
- iWEop  in  1  marks the word written with iWEn as last of packet.
- iWDrop  in  1  discard the uncommitted packet (single-cycle pulse).
- qWFull  out  1  no free word, measured against the speculative pointer.
- qWAlmostFull  out  1  free words <= pAFullThresh.
- qvWCount  out  pDepthWidth+1  occupied words, speculative wptr minus synced rptr.
- qWOverflow  out  1  one-cycle pulse, packet auto-dropped.
- iREn  in  1  pop request.
- ovDataOut  out  pWordWidth  head word, valid while !qREmpty.
- ovREop  out  1  EOP bit of the head word.
- qREmpty  out  1  no committed word available.
- qRAlmostEmpty  out  1  committed readable words <= pAEmptyThresh.
- qvRNumberLeft  out  pDepthWidth+1  committed readable words.

Behaviour:
- Reset values:
  - All pointers = 0.
  - qWFull = 0, qWAlmostFull = 0, qvWCount = 0, qWOverflow = 0.
  - qREmpty = 1, qRAlmostEmpty = 1, qvRNumberLeft = 0.
  - ovDataOut = 0, ovREop = 0.
  - Write FSM = IDLE.
  - RAM contents are not reset.
- Storage: RAM (pWordWidth+1) wide; bit pWordWidth holds EOP. All pointers are pDepthWidth+1 bits binary, wrapping modulo 2^(pDepthWidth+1).
- Write pointers:
  - wptr_spec advances on every accepted write.
  - wptr_commit is loaded with wptr_spec+1 on an accepted write with iWEop.
  - Only the Gray code of wptr_commit crosses to ReadClock, through pSyncStages flops.
- Accepted write: iWEn && !qWFull && state != DISCARD.
- Write FSM:
  - IDLE: an accepted write without EOP goes to ACTIVE; an accepted write with EOP (1-word packet) commits and stays in IDLE.
  - ACTIVE: an accepted write with EOP commits and goes to IDLE. iWDrop sets wptr_spec = wptr_commit and goes to IDLE. iWEn && qWFull triggers an overflow: wptr_spec = wptr_commit, qWOverflow pulses, go to DISCARD.
  - DISCARD: all writes are ignored. iWEn && iWEop goes to IDLE. iWDrop goes to IDLE.
  - iWDrop in IDLE has no effect.
  - iWDrop coincident with iWEn in ACTIVE: the drop wins and the word is discarded.
- Write in IDLE while qWFull: the word is ignored, no overflow and no state change. This is the caller's error.
- Write flags: qvWCount, qWFull (qvWCount == 2^pDepthWidth) and qWAlmostFull are registered every WriteClock. They use the post-update wptr_spec and the synced/converted rptr, so they are conservative.
- Read side:
  - Read pointer Gray code is synchronised into WriteClock through pSyncStages flops.
  - The committed write pointer is converted Gray-to-binary into the read domain.
  - qvRNumberLeft = wptr_commit_sync - rptr, registered.
- Read output: show-ahead with an output register.
  - While !qREmpty, ovDataOut/ovREop hold the head word.
  - iREn && !qREmpty pops it; the next word, if any, is presented on the following ReadClock edge, else qREmpty = 1 on that edge.
  - iREn while qREmpty is ignored.
- Latency:
  - Commit to qREmpty deassert: at most pSyncStages+3 ReadClock cycles.
  - Pop to freed space seen in qvWCount: at most pSyncStages+2 WriteClock cycles.
- Packet granularity: the read side never sees part of an uncommitted packet. Once the first word of a committed packet is visible, the packet is fully readable without empty gaps.
- Simultaneous full and drop: the drop frees space on the next WriteClock edge.
- A packet longer than 2^pDepthWidth always overflows and is dropped.

Test Plan:
- Settings: pDepthWidth=4, pWordWidth=8, pSyncStages=2, pAFullThresh=4, pAEmptyThresh=2.
- Reset mid-traffic: qREmpty=1, qvWCount=0, qvRNumberLeft=0, FSM IDLE, no spurious pop.
- Write 5-word packet 0x10..0x14, EOP on 0x14:
  - qREmpty stays 1 until EOP is written.
  - qREmpty falls within 5 ReadClock cycles; qvRNumberLeft=5.
  - Pops return 0x10..0x14 with ovREop=1 only on 0x14.
- Write 3 words, pulse iWDrop, then write 2-word packet 0xA0,0xA1(EOP): reader sees only 0xA0,0xA1; qvWCount returns to 2.
- No reads, write 17-word packet: qWFull=1 at 16 words; the 17th iWEn pulses qWOverflow; qvWCount returns to 0 after the update; following words are ignored until EOP; qREmpty stays 1.
- Fill with 12 committed words: qWAlmostFull=1 (free=4). Pop to 2 words left: qRAlmostEmpty=1.
- Clock ratios 1:1, 3:1 and 1:3 with random packets, drops and back-pressure: scoreboarded data and EOP match; pointers wrap past 32 correctly; no read while qREmpty.
